idct_coef_mult_pipe: RTL and testbench

//  Pipelined, parametrised constant-coefficient multiplier pair for the IDCT row/column engines.

---
 rtl/idct_coef_mult_pipe.sv | 197 +++++++++++++++++++
 tb/tb_idct_coef_mult_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_coef_mult_pipe.sv
// idct_coef_mult_pipe: three-stage shift-add multiplier pair for the IDCT cosine coefficients.
// Define IDCT_MULT_SAT_EN to saturate (instead of wrap) when reducing the result to OW bits.
module idct_coef_mult_pipe #(
  parameter int DW    = 12,
  parameter int OW    = DW + 12,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_a,
  input  logic signed [DW-1:0] in_b,
  input  logic [1:0]           code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_a,
  output logic signed [OW-1:0] out_b,
  output logic [1:0]           out_code,
  output logic                 busy
);

  localparam int PW = DW + 12;
  localparam int NT = 6;

  // Shift amount per code and term slot: -1 = empty slot, -2 = rounding constant 128.
  localparam int SH_A [4][NT] = '{
    '{ 9,  5,  4,  2,  0, -1},
    '{10,  6,  4,  2, -1, -1},
    '{11,  8,  6,  5,  3, -1},
    '{ 7,  5,  4,  2,  0, -2}};
  localparam int SH_B [4][NT] = '{
    '{11,  9,  8,  4,  3,  0},
    '{11,  9,  6,  5,  4,  2},
    '{10,  9,  6,  3,  0, -1},
    '{ 7,  5,  4,  2,  0, -2}};

`ifdef IDCT_MULT_SAT_EN
  localparam int XW = (OW > PW) ? OW : PW;
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  function automatic logic signed [PW-1:0] term(input logic signed [DW-1:0] x, input int sh);
    logic signed [PW-1:0] xe;
    xe = PW'(x);
    if (sh == -2) term = PW'(128);
    else if (sh < 0) term = '0;
    else term = xe <<< sh;
  endfunction

  function automatic logic signed [OW-1:0] reduce(input logic signed [PW-1:0] v);
`ifdef IDCT_MULT_SAT_EN
    logic signed [XW-1:0] ve;
    ve = XW'(v);
    if (ve > SAT_MAX) reduce = OW'(SAT_MAX);
    else if (ve < SAT_MIN) reduce = OW'(SAT_MIN);
    else reduce = OW'(ve);
`else
    reduce = OW'(v);
`endif
  endfunction

  logic en;

  // Candidate terms for every code, built from constant shifts; the code only steers a mux.
  logic signed [PW-1:0] cand_a [4][NT];
  logic signed [PW-1:0] cand_b [4][NT];

  for (genvar gi = 0; gi < NT; gi++) begin : g_slot
    for (genvar gc = 0; gc < 4; gc++) begin : g_code
      assign cand_a[gc][gi] = term(in_a, SH_A[gc][gi]);
      assign cand_b[gc][gi] = term(in_b, SH_B[gc][gi]);
    end
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [1:0]           s1_code_q, s1_code_d;
  logic signed [PW-1:0] s1_ta_q [NT];
  logic signed [PW-1:0] s1_ta_d [NT];
  logic signed [PW-1:0] s1_tb_q [NT];
  logic signed [PW-1:0] s1_tb_d [NT];

  logic                 s2_valid_q, s2_valid_d;
  logic [1:0]           s2_code_q, s2_code_d;
  logic signed [PW-1:0] s2_pa_q [3];
  logic signed [PW-1:0] s2_pa_d [3];
  logic signed [PW-1:0] s2_pb_q [3];
  logic signed [PW-1:0] s2_pb_d [3];

  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_code_q, out_code_d;
  logic signed [OW-1:0] out_a_q, out_a_d;
  logic signed [OW-1:0] out_b_q, out_b_d;

  logic signed [PW-1:0] sum_a, sum_b, shf_a, shf_b;

  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_code  = out_code_q;
  assign busy      = s1_valid_q | s2_valid_q | out_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_ta_d    = s1_ta_q;
    s1_tb_d    = s1_tb_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_code_d  = code;
      for (int i = 0; i < NT; i++) begin
        s1_ta_d[i] = cand_a[code][i];
        s1_tb_d[i] = cand_b[code][i];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    s2_pa_d    = s2_pa_q;
    s2_pb_d    = s2_pb_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_code_d  = s1_code_q;
      for (int i = 0; i < 3; i++) begin
        s2_pa_d[i] = s1_ta_q[2*i] + s1_ta_q[2*i+1];
        s2_pb_d[i] = s1_tb_q[2*i] + s1_tb_q[2*i+1];
      end
    end
  end

  // Final sum, then mode-dependent shift and OW reduction ahead of the output register.
  always_comb begin
    sum_a = s2_pa_q[0] + s2_pa_q[1] + s2_pa_q[2];
    sum_b = s2_pb_q[0] + s2_pb_q[1] + s2_pb_q[2];
    if (s2_code_q == 2'b11) begin
      shf_a = sum_a >>> 8;
      shf_b = sum_b >>> 8;
    end else begin
      shf_a = sum_a >>> SHIFT;
      shf_b = sum_b >>> SHIFT;
    end
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_code_d  = s2_code_q;
      out_a_d     = reduce(shf_a);
      out_b_d     = reduce(shf_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_code_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      for (int i = 0; i < NT; i++) begin
        s1_ta_q[i] <= '0;
        s1_tb_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        s2_pa_q[i] <= '0;
        s2_pb_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s2_valid_q  <= s2_valid_d;
      s2_code_q   <= s2_code_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      for (int i = 0; i < NT; i++) begin
        s1_ta_q[i] <= s1_ta_d[i];
        s1_tb_q[i] <= s1_tb_d[i];
      end
      for (int i = 0; i < 3; i++) begin
        s2_pa_q[i] <= s2_pa_d[i];
        s2_pb_q[i] <= s2_pb_d[i];
      end
    end
  end

endmodule

// File: tb/tb_idct_coef_mult_pipe.sv
// Directed bench for idct_coef_mult_pipe: default, narrow-output (OW=16) and SHIFT=4 instances.
module tb_idct_coef_mult_pipe;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [1:0]        code = 2'b00;
  logic signed [11:0] in_a = '0;
  logic signed [11:0] in_b = '0;

  logic              in_ready, out_valid, busy;
  logic signed [23:0] out_a, out_b;
  logic [1:0]        out_code;

  logic              in_ready_n, out_valid_n, busy_n;
  logic signed [15:0] out_a_n, out_b_n;
  logic [1:0]        out_code_n;

  logic              in_ready_s, out_valid_s, busy_s;
  logic signed [23:0] out_a_s, out_b_s;
  logic [1:0]        out_code_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idct_coef_mult_pipe #(.DW(12), .OW(24), .SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .code(code), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_code(out_code), .busy(busy));

  idct_coef_mult_pipe #(.DW(12), .OW(16), .SHIFT(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .code(code), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_a(out_a_n), .out_b(out_b_n), .out_code(out_code_n), .busy(busy_n));

  idct_coef_mult_pipe #(.DW(12), .OW(24), .SHIFT(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .code(code), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_a(out_a_s), .out_b(out_b_s), .out_code(out_code_s), .busy(busy_s));

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, then confirms it appears exactly on the third rising edge.
  task automatic beat_single(input logic [1:0] c, input int a, input int b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    code      = c;
    in_a      = 12'(a);
    in_b      = 12'(b);
    step();
    in_valid = 1'b0;
    check("latency_edge1", out_valid, 0);
    step();
    check("latency_edge2", out_valid, 0);
    step();
    check("latency_edge3", out_valid, 1);
    $display("beat code=%0d a=%0d b=%0d -> out_a=%0d out_b=%0d", c, a, b, out_a, out_b);
  endtask

  function automatic logic signed [63:0] model(input int c, input int x, input bit is_b);
    int k;
    if (c == 3) return 64'((x * 181 + 128) >>> 8);
    case (c)
      0:       k = is_b ? 2841 : 565;
      1:       k = is_b ? 2676 : 1108;
      default: k = is_b ? 1609 : 2408;
    endcase
    return 64'(x * k);
  endfunction

  logic [31:0]        rdy_pat = 32'hB2E5_9C74;
  logic signed [63:0] qa[$];
  logic signed [63:0] qb[$];
  logic signed [63:0] qc[$];
  logic signed [63:0] ea, eb, ec;
  logic               prev_stall;
  logic signed [23:0] sv_a, sv_b;
  logic [1:0]         sv_code;
  int sent, rcvd, cyc, va, vb;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_code", out_code, 0);

    // Modes 00..10, default and SHIFT=4 and narrow instances
    beat_single(2'b00, 100, 100);
    check("m00_a", out_a, 56500);
    check("m00_b", out_b, 284100);
    check("m00_code", out_code, 0);
    check("m00_shift_a", out_a_s, 3531);
    check("m00_shift_b", out_b_s, 17756);
`ifdef IDCT_MULT_SAT_EN
    check("m00_narrow_a", out_a_n, 32767);
    check("m00_narrow_b", out_b_n, 32767);
`else
    check("m00_narrow_a", out_a_n, -9036);
    check("m00_narrow_b", out_b_n, 21956);
`endif

    beat_single(2'b01, -2048, 2047);
    check("m01_a", out_a, -2269184);
    check("m01_b", out_b, 5477772);
    check("m01_code", out_code, 1);
    check("m01_shift_a", out_a_s, -141824);
    check("m01_shift_b", out_b_s, 342360);

    beat_single(2'b10, -1, -1);
    check("m10_a", out_a, -2408);
    check("m10_b", out_b, -1609);
    check("m10_code", out_code, 2);
    check("m10_shift_a", out_a_s, -151);
    check("m10_shift_b", out_b_s, -101);

    // Mode 11, SHIFT ignored
    beat_single(2'b11, 100, 2047);
    check("m11_a_pos", out_a, 71);
    check("m11_b_max", out_b, 1447);
    check("m11_code", out_code, 3);
    check("m11_shift_a", out_a_s, 71);
    check("m11_shift_b", out_b_s, 1447);
    check("m11_narrow_b", out_b_n, 1447);

    beat_single(2'b11, -100, -2048);
    check("m11_a_neg", out_a, -71);
    check("m11_b_min", out_b, -1448);
    check("m11_shift_b_min", out_b_s, -1448);

    // Narrow output width
    beat_single(2'b00, 0, 2047);
    check("wide_b", out_b, 5815527);
`ifdef IDCT_MULT_SAT_EN
    check("narrow_b", out_b_n, 32767);
`else
    check("narrow_b", out_b_n, -17177);
`endif

    // SHIFT floors toward -inf
    beat_single(2'b01, -3, 0);
    check("shift_floor_a", out_a_s, -208);
    check("noshift_a", out_a, -3324);

    step();
    check("drain_empty", out_valid, 0);

    // Streaming with backpressure
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
    sv_a = '0; sv_b = '0; sv_code = '0;
    while ((sent < 16 || rcvd < 16) && cyc < 300) begin
      out_ready = rdy_pat[cyc % 32];
      in_valid  = (sent < 16);
      va = sent * 137 - 1000;
      vb = 700 - sent * 97;
      code = 2'(sent % 4);
      in_a = 12'(va);
      in_b = 12'(vb);
      #1;
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_a", out_a, sv_a);
        check("stall_b", out_b, sv_b);
        check("stall_code", out_code, sv_code);
      end
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          check("stream_extra_beat", rcvd, 16);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
          check("stream_a", out_a, ea);
          check("stream_b", out_b, eb);
          check("stream_code", out_code, ec);
          $display("stream beat %0d code=%0d out_a=%0d out_b=%0d", rcvd, out_code, out_a, out_b);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        qa.push_back(model(sent % 4, va, 1'b0));
        qb.push_back(model(sent % 4, vb, 1'b1));
        qc.push_back(64'(sent % 4));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      sv_a = out_a; sv_b = out_b; sv_code = out_code;
      cyc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 16);
    check("stream_rcvd", rcvd, 16);

    // Asynchronous reset with three beats in flight and output stalled
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code = 2'b00; in_a = 12'sd10; in_b = 12'sd20;
    step();
    in_a = 12'sd11;
    step();
    in_a = 12'sd12;
    step();
    in_valid = 1'b0;
    check("flight_valid", out_valid, 1);
    check("flight_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_out_a", out_a, 0);
    check("arst_out_b", out_b, 0);
    check("arst_out_code", out_code, 0);
    check("arst_narrow_b", out_b_n, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    beat_single(2'b10, -1, -1);
    check("post_rst_a", out_a, -2408);
    check("post_rst_b", out_b, -1609);
    check("post_rst_code", out_code, 2);
    step();
    check("post_rst_no_stale", out_valid, 0);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
